// File: rtl/xbar_cell_ctrl.sv
// Cell-slot controller for an input-queued crossbar: tracks VOQ occupancy, runs one
// scheduler matching per slot and holds the resulting crossbar configuration for a cell time.
module xbar_cell_ctrl #(
    parameter int NUM_PORTS     = 4,
    parameter int CELL_CYCLES   = 8,
    parameter int CNT_WIDTH     = 4,
    parameter int SCHED_TIMEOUT = 16,
    localparam int PW           = $clog2(NUM_PORTS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           enq_valid,
    input  logic [NUM_PORTS*PW-1:0]        enq_dest,
    output logic [NUM_PORTS*NUM_PORTS-1:0] request,
    output logic                           sched_start,
    input  logic                           match_valid,
    input  logic [NUM_PORTS*PW-1:0]        match_dest,
    input  logic [NUM_PORTS-1:0]           match_given,
    output logic [NUM_PORTS*PW-1:0]        xbar_dest,
    output logic [NUM_PORTS-1:0]           xbar_en,
    output logic [NUM_PORTS-1:0]           deq_valid,
    output logic [NUM_PORTS*PW-1:0]        deq_dest,
    output logic [NUM_PORTS-1:0]           enq_drop,
    output logic                           err
);

    localparam int NN = NUM_PORTS * NUM_PORTS;
    localparam int WW = (SCHED_TIMEOUT > 2) ? $clog2(SCHED_TIMEOUT) : 1;
    localparam int XW = (CELL_CYCLES > 2) ? $clog2(CELL_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [WW-1:0]        WAIT_END = WW'(SCHED_TIMEOUT - 1);
    localparam logic [XW-1:0]        XFER_END = XW'(CELL_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_XFER} state_t;

    state_t                          state_q, state_d;
    logic [NN-1:0][CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [WW-1:0]                   wait_q, wait_d;
    logic [XW-1:0]                   xfer_q, xfer_d;
    logic [NN-1:0]                   nonempty;
    logic [NUM_PORTS-1:0]            empty_grant, grant_ok, drop_d;
    logic                            enq_hit, deq_hit;
    logic [NN-1:0]                   request_d;
    logic                            sched_start_d, err_d;
    logic [NUM_PORTS*PW-1:0]         xbar_dest_d, deq_dest_d;
    logic [NUM_PORTS-1:0]            xbar_en_d, deq_valid_d;

    // Occupancy update: an enqueue and a dequeue of the same VOQ cancel out, so a full
    // VOQ still accepts a cell in the cycle it is being drained.
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d       = cnt_q;
        drop_d      = '0;
        nonempty    = '0;
        empty_grant = '0;
        enq_hit     = 1'b0;
        deq_hit     = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                enq_hit = enq_valid[i] && (enq_dest[i*PW +: PW] == PW'(j));
                deq_hit = deq_valid[i] && (deq_dest[i*PW +: PW] == PW'(j));
                nonempty[i*NUM_PORTS+j] = (cnt_q[i*NUM_PORTS+j] != '0);
                if ((match_dest[i*PW +: PW] == PW'(j)) && (cnt_q[i*NUM_PORTS+j] == '0))
                    empty_grant[i] = 1'b1;
                if (enq_hit && !deq_hit) begin
                    if (cnt_q[i*NUM_PORTS+j] != CNT_MAX)
                        cnt_d[i*NUM_PORTS+j] = cnt_q[i*NUM_PORTS+j] + CNT_ONE;
                    else
                        drop_d[i] = 1'b1;
                end else if (deq_hit && !enq_hit && (cnt_q[i*NUM_PORTS+j] != '0)) begin
                    cnt_d[i*NUM_PORTS+j] = cnt_q[i*NUM_PORTS+j] - CNT_ONE;
                end
            end
        end
    end

    assign grant_ok = match_given & ~empty_grant;

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        xfer_d        = xfer_q;
        request_d     = request;
        sched_start_d = 1'b0;
        xbar_dest_d   = xbar_dest;
        xbar_en_d     = xbar_en;
        deq_valid_d   = '0;
        deq_dest_d    = '0;
        err_d         = err;
        unique case (state_q)
            ST_IDLE: begin
                if (|nonempty) begin
                    state_d       = ST_REQ;
                    request_d     = nonempty;
                    sched_start_d = 1'b1;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
                wait_d  = '0;
            end
            ST_WAIT: begin
                if (match_valid) begin
                    state_d     = ST_XFER;
                    xfer_d      = '0;
                    request_d   = '0;
                    xbar_dest_d = match_dest;
                    xbar_en_d   = grant_ok;
                    deq_valid_d = grant_ok;
                    for (int i = 0; i < NUM_PORTS; i++)
                        if (grant_ok[i]) deq_dest_d[i*PW +: PW] = match_dest[i*PW +: PW];
                    if (|(match_given & empty_grant)) err_d = 1'b1;
                end else if (wait_q == WAIT_END) begin
                    state_d   = ST_IDLE;
                    request_d = '0;
                    err_d     = 1'b1;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            ST_XFER: begin
                // Counters already reflect this slot's dequeues by the last cycle.
                if (xfer_q == XFER_END) begin
                    xbar_en_d   = '0;
                    xbar_dest_d = '0;
                    if (|nonempty) begin
                        state_d       = ST_REQ;
                        request_d     = nonempty;
                        sched_start_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    xfer_d = xfer_q + XW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    // NOTE: the occupancy counters are control state, not a data store, so they are reset too.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wait_q      <= '0;
            xfer_q      <= '0;
            request     <= '0;
            sched_start <= 1'b0;
            xbar_dest   <= '0;
            xbar_en     <= '0;
            deq_valid   <= '0;
            deq_dest    <= '0;
            enq_drop    <= '0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            xfer_q      <= xfer_d;
            request     <= request_d;
            sched_start <= sched_start_d;
            xbar_dest   <= xbar_dest_d;
            xbar_en     <= xbar_en_d;
            deq_valid   <= deq_valid_d;
            deq_dest    <= deq_dest_d;
            enq_drop    <= drop_d;
            err         <= err_d;
        end
    end

endmodule

// File: tb/tb_xbar_cell_ctrl.sv
// Self-checking bench for xbar_cell_ctrl (N=4, CELL_CYCLES=8, CNT_WIDTH=2, SCHED_TIMEOUT=16):
// table-driven single-slot vectors plus hand-written reset, full-VOQ, timeout and mid-slot sequences.
module tb_xbar_cell_ctrl;

    localparam int N    = 4;
    localparam int PW   = 2;
    localparam int CELL = 8;
    localparam int TOUT = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  enq_valid;
    logic [N*PW-1:0] enq_dest;
    logic [N*N-1:0] request;
    logic          sched_start;
    logic          match_valid;
    logic [N*PW-1:0] match_dest;
    logic [N-1:0]  match_given;
    logic [N*PW-1:0] xbar_dest;
    logic [N-1:0]  xbar_en;
    logic [N-1:0]  deq_valid;
    logic [N*PW-1:0] deq_dest;
    logic [N-1:0]  enq_drop;
    logic          err;

    xbar_cell_ctrl #(
        .NUM_PORTS(N), .CELL_CYCLES(CELL), .CNT_WIDTH(2), .SCHED_TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_dest(enq_dest),
        .request(request), .sched_start(sched_start),
        .match_valid(match_valid), .match_dest(match_dest), .match_given(match_given),
        .xbar_dest(xbar_dest), .xbar_en(xbar_en),
        .deq_valid(deq_valid), .deq_dest(deq_dest),
        .enq_drop(enq_drop), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  ev;    // enq_valid for one cycle
        logic [7:0]  ed;    // enq_dest
        logic [15:0] req;   // request expected in REQ
        logic [3:0]  given; // match_given
        logic [7:0]  md;    // match_dest
        logic [3:0]  en;    // expected xbar_en / deq_valid
        logic [15:0] nxt;   // request expected after the slot (0 = back to IDLE)
        logic        err;   // expected err after the slot
    } vec_t;

    typedef struct {
        logic [3:0] en;
        logic [7:0] dest;
    } exp_t;

    vec_t vecs[5];
    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enq_valid   = '0;
        enq_dest    = '0;
        match_valid = 1'b0;
        match_given = '0;
        match_dest  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_sched(input string name, input int budget, output int n);
        n = 0;
        while (!sched_start && n < budget) begin
            tick();
            n++;
        end
        check({name, "_sched_seen"}, sched_start, 1'b1);
    endtask

    // Drives one match pulse in WAIT and compares the first XFER cycle against the scoreboard.
    task automatic do_match(input string name, input logic [3:0] given, input logic [7:0] md,
                            input logic [3:0] exp_en);
        exp_t e;
        logic [7:0] mask;
        sb_q.push_back('{en: exp_en, dest: md});
        match_valid = 1'b1;
        match_given = given;
        match_dest  = md;
        tick();
        match_valid = 1'b0;
        match_given = '0;
        match_dest  = '0;
        e = sb_q.pop_front();
        mask = '0;
        for (int i = 0; i < N; i++) if (e.en[i]) mask[i*PW +: PW] = 2'b11;
        check({name, "_xbar_en"},   xbar_en,          e.en);
        check({name, "_deq_valid"}, deq_valid,        e.en);
        check({name, "_xbar_dest"}, xbar_dest,        e.dest);
        check({name, "_deq_dest"},  deq_dest & mask,  e.dest & mask);
        check({name, "_req_clr"},   request,          16'h0);
    endtask

    // Entered in the REQ cycle; leaves one cycle after the last XFER cycle.
    task automatic slot(input string name, input logic [3:0] given, input logic [7:0] md,
                        input logic [15:0] exp_req, input logic [3:0] exp_en,
                        input logic [15:0] exp_nxt);
        int held;
        check({name, "_req"}, request, exp_req);
        tick();
        check({name, "_start_pulse"}, sched_start, 1'b0);
        do_match(name, given, md, exp_en);
        held = 0;
        for (int k = 1; k < CELL; k++) begin
            tick();
            if (xbar_en === exp_en && deq_valid === 4'b0) held++;
        end
        check({name, "_held"}, held, CELL - 1);
        tick();
        check({name, "_en_off"},   xbar_en,     4'b0);
        check({name, "_next_st"},  sched_start, exp_nxt != 16'h0);
        check({name, "_next_req"}, request,     exp_nxt);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;

        vecs[0] = '{"single",   4'b0010, 8'h08, 16'h0040, 4'b0010, 8'h08, 4'b0010, 16'h0000, 1'b0};
        vecs[1] = '{"perm",     4'b1111, 8'h39, 16'h1842, 4'b1111, 8'h39, 4'b1111, 16'h0000, 1'b0};
        vecs[2] = '{"bad_gnt",  4'b0100, 8'h30, 16'h0800, 4'b0101, 8'h31, 4'b0100, 16'h0000, 1'b1};
        vecs[3] = '{"partial",  4'b1001, 8'hC0, 16'h8001, 4'b1000, 8'hC0, 4'b1000, 16'h0001, 1'b0};
        vecs[4] = '{"wrong_dst",4'b0010, 8'h08, 16'h0040, 4'b0010, 8'h0C, 4'b0000, 16'h0040, 1'b1};

        // Reset held with arrivals present: nothing may be counted.
        idle_inputs();
        reset     = 1'b0;
        enq_valid = 4'b1111;
        enq_dest  = 8'hE4;
        repeat (3) tick();
        reset = 1'b1;
        idle_inputs();
        check("rst_outputs", {request, sched_start, xbar_dest, xbar_en, deq_valid, deq_dest, enq_drop, err}, '0);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (sched_start !== 1'b0 || request !== 16'h0) cnt++;
        end
        check("rst_counters_zero", cnt, 0);
        match_valid = 1'b1;
        match_given = 4'b1111;
        match_dest  = 8'hE4;
        tick();
        idle_inputs();
        tick();
        check("idle_match_ignored", {xbar_en, deq_valid, err}, '0);

        foreach (vecs[v]) begin
            do_reset();
            enq_valid = vecs[v].ev;
            enq_dest  = vecs[v].ed;
            tick();
            idle_inputs();
            check({vecs[v].name, "_no_early_start"}, sched_start, 1'b0);
            wait_sched(vecs[v].name, 4, n);
            check({vecs[v].name, "_start_latency"}, n, 1);
            slot(vecs[v].name, vecs[v].given, vecs[v].md, vecs[v].req, vecs[v].en, vecs[v].nxt);
            check({vecs[v].name, "_err"}, err, vecs[v].err);
        end

        // Full VOQ: four arrivals to VOQ(0,3) with a 2-bit counter.
        do_reset();
        enq_valid = 4'b0001;
        enq_dest  = 8'h03;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("full_drop_%0d", k), enq_drop, (k == 3) ? 4'b0001 : 4'b0000);
        end
        idle_inputs();
        do_match("full_deq", 4'b0001, 8'h03, 4'b0001);
        enq_valid = 4'b0001;
        enq_dest  = 8'h03;
        tick();
        check("full_enq_deq_no_drop", enq_drop, 4'b0000);
        tick();
        check("full_after_drop", enq_drop, 4'b0001);
        idle_inputs();
        n = 0;
        while (xbar_en !== 4'b0 && n < 20) begin
            tick();
            n++;
        end
        check("full_xfer_rest", n, 6);
        check("full_next_start", sched_start, 1'b1);
        for (int k = 0; k < 3; k++)
            slot($sformatf("drain_%0d", k), 4'b0001, 8'h03, 16'h0008, 4'b0001,
                 (k < 2) ? 16'h0008 : 16'h0000);
        check("full_err_clean", err, 1'b0);

        // Scheduler timeout.
        do_reset();
        enq_valid = 4'b1000;
        enq_dest  = 8'h00;
        tick();
        idle_inputs();
        wait_sched("tout", 4, n);
        tick();
        n = 0;
        while (request !== 16'h0 && n < 40) begin
            tick();
            n++;
        end
        check("tout_wait_cycles", n, TOUT);
        check("tout_err", err, 1'b1);
        check("tout_idle", sched_start, 1'b0);
        tick();
        check("tout_restart", sched_start, 1'b1);
        slot("tout_slot", 4'b1000, 8'h00, 16'h1000, 4'b1000, 16'h0000);
        check("tout_err_sticky", err, 1'b1);

        // Reset in the third XFER cycle abandons the slot and the leftover cell.
        do_reset();
        enq_valid = 4'b0010;
        enq_dest  = 8'h08;
        tick();
        tick();
        idle_inputs();
        wait_sched("mid", 4, n);
        tick();
        do_match("mid", 4'b0010, 8'h08, 4'b0010);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("mid_rst_outputs", {request, sched_start, xbar_en, deq_valid, err}, '0);
        reset = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (sched_start !== 1'b0 || deq_valid !== 4'b0 || xbar_en !== 4'b0) cnt++;
        end
        check("mid_rst_quiet", cnt, 0);
        check("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
